// File: rtl/data_memory_responder.sv
// Data-memory responder for the Memory stage: word-organised RAM serving one load or store
// at a time with fixed wait states and one-cycle response pulses.
module data_memory_responder #(
  parameter int    MEMORY_BYTES  = 65536,
  parameter int    LOAD_LATENCY  = 1,
  parameter int    STORE_LATENCY = 1,
  parameter string INIT_FILE     = ""
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        loadRequest,
  input  logic        storeValid,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  logic [3:0]  storeByteEnable,
  input  logic        abort,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        rangeError
);
  localparam int AW     = $clog2(MEMORY_BYTES);
  localparam int WORDS  = MEMORY_BYTES / 4;
  localparam int MAXLAT = (LOAD_LATENCY > STORE_LATENCY) ? LOAD_LATENCY : STORE_LATENCY;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_WAIT, LOAD_RESP, STORE_WAIT, STORE_RESP} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic            runQ;
  logic            loadValidQ;
  logic            storeDoneQ;
  logic            rangeQ;
  logic [31:0]     addrQ;
  logic [31:0]     dataQ;
  logic [3:0]      beQ;
  logic [31:0]     ram [WORDS];

  logic [31:0]     opAddr;
  logic [31:0]     opData;
  logic [3:0]      opBe;
  logic [AW-3:0]   opIndex;
  logic            opInRange;
  logic            acceptStore;
  logic            acceptLoad;
  logic            loadFire;
  logic            storeFire;

  // In IDLE the operation is being accepted this edge, so take the live inputs.
  always_comb begin
    opAddr = addrQ;
    opData = dataQ;
    opBe   = beQ;
    if (state == IDLE) begin
      opAddr = address;
      opData = storeData;
      opBe   = storeByteEnable;
    end
  end

  assign opIndex   = opAddr[AW-1:2];
  assign opInRange = (opAddr < 32'(MEMORY_BYTES));

  // runQ keeps the block deaf while reset is asserted, so no write can slip in under reset.
  assign acceptStore = (state == IDLE) && runQ && storeValid;
  assign acceptLoad  = (state == IDLE) && runQ && !storeValid && loadRequest && !abort;
  assign loadFire    = (acceptLoad && (LOAD_LATENCY == 1)) ||
                       ((state == LOAD_WAIT) && (counter == '0) && !abort);
  assign storeFire   = (acceptStore && (STORE_LATENCY == 1)) ||
                       ((state == STORE_WAIT) && (counter == '0));

  assign loadDataValid = loadValidQ && !abort;
  assign storeComplete = storeDoneQ;
  assign rangeError    = rangeQ && !(abort && loadValidQ);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      counter    <= '0;
      runQ       <= 1'b0;
      loadData   <= '0;
      loadValidQ <= 1'b0;
      storeDoneQ <= 1'b0;
      rangeQ     <= 1'b0;
    end else begin
      runQ       <= 1'b1;
      loadValidQ <= loadFire;
      storeDoneQ <= storeFire;
      rangeQ     <= (loadFire || storeFire) && !opInRange;
      if (loadFire) loadData <= opInRange ? ram[opIndex] : 32'h0;
      case (state)
        IDLE: begin
          if (acceptStore) begin
            if (STORE_LATENCY == 1) state <= STORE_RESP;
            else begin
              state   <= STORE_WAIT;
              counter <= CW'(STORE_LATENCY - 2);
            end
          end else if (acceptLoad) begin
            if (LOAD_LATENCY == 1) state <= LOAD_RESP;
            else begin
              state   <= LOAD_WAIT;
              counter <= CW'(LOAD_LATENCY - 2);
            end
          end
        end
        LOAD_WAIT: begin
          if (abort)                state <= IDLE;
          else if (counter == '0)   state <= LOAD_RESP;
          else                      counter <= counter - CW'(1);
        end
        STORE_WAIT: begin
          if (counter == '0) state <= STORE_RESP;
          else               counter <= counter - CW'(1);
        end
        LOAD_RESP:  state <= IDLE;
        STORE_RESP: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Request payload is only meaningful once accepted, so it carries no reset.
  always_ff @(posedge clock) begin
    if (acceptStore || acceptLoad) addrQ <= address;
    if (acceptStore) begin
      dataQ <= storeData;
      beQ   <= storeByteEnable;
    end
  end

  always_ff @(posedge clock) begin
    if (storeFire && opInRange) begin
      for (int i = 0; i < 4; i++) begin
        if (opBe[i]) ram[opIndex][8*i +: 8] <= opData[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: instance A runs 1/1 latency, instance B runs load/store latency 3/3.
module tb_data_memory_responder;
  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        aRst, aLoad, aStore, aAbort;
  logic [31:0] aAddr, aData;
  logic [3:0]  aBe;
  logic [31:0] aRdata;
  logic        aValid, aDone, aRerr;

  logic        bRst, bLoad, bStore, bAbort;
  logic [31:0] bAddr, bData;
  logic [3:0]  bBe;
  logic [31:0] bRdata;
  logic        bValid, bDone, bRerr;

  always #5 clk = ~clk;

  data_memory_responder #(.MEMORY_BYTES(65536), .LOAD_LATENCY(1), .STORE_LATENCY(1)) u_a (
    .clock(clk), .resetN(aRst), .loadRequest(aLoad), .storeValid(aStore),
    .address(aAddr), .storeData(aData), .storeByteEnable(aBe), .abort(aAbort),
    .loadData(aRdata), .loadDataValid(aValid), .storeComplete(aDone), .rangeError(aRerr));

  data_memory_responder #(.MEMORY_BYTES(65536), .LOAD_LATENCY(3), .STORE_LATENCY(3)) u_b (
    .clock(clk), .resetN(bRst), .loadRequest(bLoad), .storeValid(bStore),
    .address(bAddr), .storeData(bData), .storeByteEnable(bBe), .abort(bAbort),
    .loadData(bRdata), .loadDataValid(bValid), .storeComplete(bDone), .rangeError(bRerr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_store(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] be,
                         input logic er, input string tag);
    aAddr = ad; aData = d; aBe = be; aStore = 1'b1;
    chk({tag, "_pre"}, aDone, 0);
    step();
    chk(tag, aDone, 1);
    chk({tag, "_rerr"}, aRerr, er);
    aStore = 1'b0;
    step();
    chk({tag, "_post"}, aDone, 0);
  endtask

  task automatic a_load(input logic [31:0] ad, input logic [31:0] d, input logic er,
                        input string tag);
    aAddr = ad; aLoad = 1'b1;
    chk({tag, "_pre"}, aValid, 0);
    step();
    chk(tag, aValid, 1);
    chk({tag, "_data"}, aRdata, d);
    chk({tag, "_rerr"}, aRerr, er);
    aLoad = 1'b0;
    step();
    chk({tag, "_post"}, aValid, 0);
    chk({tag, "_hold"}, aRdata, d);
  endtask

  task automatic b_store(input logic [31:0] ad, input logic [31:0] d, input string tag);
    bAddr = ad; bData = d; bBe = 4'hF; bStore = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk({tag, "_wait"}, bDone, 0);
    end
    step();
    chk(tag, bDone, 1);
    bStore = 1'b0;
    step();
    chk({tag, "_post"}, bDone, 0);
  endtask

  task automatic b_load(input logic [31:0] ad, input logic [31:0] d, input string tag);
    bAddr = ad; bLoad = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk({tag, "_wait"}, bValid, 0);
    end
    step();
    chk(tag, bValid, 1);
    chk({tag, "_data"}, bRdata, d);
    bLoad = 1'b0;
    step();
    chk({tag, "_post"}, bValid, 0);
  endtask

  initial begin
    aRst = 1'b0; aLoad = 1'b0; aStore = 1'b0; aAbort = 1'b0; aAddr = '0; aData = '0; aBe = '0;
    bRst = 1'b0; bLoad = 1'b0; bStore = 1'b0; bAbort = 1'b0; bAddr = '0; bData = '0; bBe = '0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      step();
      aLoad = 1'($urandom()); aStore = 1'($urandom()); aAbort = 1'($urandom());
      aAddr = $urandom() & 32'h0000_FFFF; aData = $urandom(); aBe = 4'($urandom());
      chk("rst_valid", aValid, 0);
      chk("rst_done", aDone, 0);
      chk("rst_rerr", aRerr, 0);
      chk("rst_data", aRdata, 0);
    end
    aLoad = 1'b0; aStore = 1'b0; aAbort = 1'b0;
    aRst = 1'b1; bRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", aValid, 0);
      chk("idle_done", aDone, 0);
      chk("idle_rerr", aRerr, 0);
    end

    // Word store/load
    a_store(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, "st_word");
    a_load(32'h100, 32'hDEADBEEF, 1'b0, "ld_word");

    // Byte lane merge
    a_store(32'h100, 32'h11223344, 4'hF, 1'b0, "st_base");
    a_store(32'h101, 32'h0000AA00, 4'b0010, 1'b0, "st_lane");
    a_load(32'h100, 32'h1122AA44, 1'b0, "ld_lane");
    a_store(32'h100, 32'hFFFFFFFF, 4'h0, 1'b0, "st_nobe");
    a_load(32'h100, 32'h1122AA44, 1'b0, "ld_nobe");

    // Simultaneous store and load: store first, load sees new data
    a_store(32'h200, 32'h0, 4'hF, 1'b0, "st_clr");
    aAddr = 32'h200; aData = 32'h5A5A5A5A; aBe = 4'hF; aStore = 1'b1; aLoad = 1'b1;
    step();
    chk("both_done", aDone, 1);
    chk("both_novalid", aValid, 0);
    aStore = 1'b0;
    step();
    chk("both_done_end", aDone, 0);
    chk("both_valid_early", aValid, 0);
    step();
    chk("both_valid", aValid, 1);
    chk("both_data", aRdata, 32'h5A5A5A5A);
    aLoad = 1'b0;
    step();
    chk("both_post", aValid, 0);

    // Out-of-range accesses
    a_store(32'h10100, 32'hFFFFFFFF, 4'hF, 1'b1, "st_oor");
    a_load(32'h100, 32'h1122AA44, 1'b0, "ld_alias");
    a_load(32'h20000, 32'h0, 1'b1, "ld_oor");
    a_load(32'hFFFF, 32'h0, 1'b0, "ld_top");

    // Abort masking in LOAD_RESP and blocking acceptance in IDLE
    aAddr = 32'h20000; aLoad = 1'b1;
    step();
    aAbort = 1'b1;
    #1;
    chk("abort_resp_valid", aValid, 0);
    chk("abort_resp_rerr", aRerr, 0);
    aLoad = 1'b0;
    step();
    aAbort = 1'b0;
    aAddr = 32'h100; aLoad = 1'b1; aAbort = 1'b1;
    step();
    aLoad = 1'b0; aAbort = 1'b0;
    chk("abort_idle_valid", aValid, 0);
    step();
    chk("abort_idle_valid2", aValid, 0);

    // Latency 3, request held across the pulse
    b_store(32'h40, 32'hCAFEF00D, "b_st");
    bAddr = 32'h40; bLoad = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lat_wait1", bValid, 0);
    end
    step();
    chk("lat_pulse1", bValid, 1);
    chk("lat_data1", bRdata, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lat_wait2", bValid, 0);
    end
    step();
    chk("lat_pulse2", bValid, 1);
    bLoad = 1'b0;
    step();
    chk("lat_post", bValid, 0);

    // Abort during LOAD_WAIT
    bAddr = 32'h40; bLoad = 1'b1;
    step();
    bAbort = 1'b1; bLoad = 1'b0;
    step();
    bAbort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_wait_valid", bValid, 0);
      step();
    end

    // Reset during STORE_WAIT leaves RAM untouched
    bAddr = 32'h40; bData = 32'h12345678; bBe = 4'hF; bStore = 1'b1;
    step();
    bRst = 1'b0; bStore = 1'b0;
    #1;
    chk("rst_sw_done", bDone, 0);
    step();
    chk("rst_sw_done2", bDone, 0);
    bRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_sw_idle", bDone, 0);
    end
    b_load(32'h40, 32'hCAFEF00D, "rst_sw_ld");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
